run_ctrl: RTL and testbench
===========================

# run_ctrl

Sequencing controller for the ROE core. It owns the program counter and the `req`/`ack` run handshake, and decides which cycles commit results to the register file and data memory. Each `req` runs the instruction stream from the current PC until a halt instruction, then raises `ack`. It sits between the top-level `prog` ports and the fetch/decode/datapath logic, and it is the only source of PC updates and commit strobes.

## Interface
- `PC_W`, default 10: program counter width; instruction memory depth is 2^PC_W.
- `CNT_W`, default 16: width of the per-run cycle counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  run request from the host; level-sampled.
- `ack`  out  1  run complete; high from the end of a run until the next run starts.
- `halt`  in  1  decoder: the current instruction is the halt/done opcode.
- `is_load`  in  1  decoder: the current instruction is `ld`, which needs one extra data-memory cycle.
- `branch_en`  in  1  datapath: the current instruction is a taken branch.
- `branch_target`  in  PC_W  branch address from the branch LUT.
- `pc`  out  PC_W  instruction fetch address.
- `commit`  out  1  gate for the RF write enable and the DM write enable.
- `running`  out  1  high in RUN and LDWAIT.
- `cycle_cnt`  out  CNT_W  number of cycles spent in the last or current run, saturating.

## Operation
- States:
  - IDLE: waiting for a run.
  - RUN: executing one instruction per cycle.
  - LDWAIT: second cycle of a load.
  - DONE: run finished, waiting for `req` to drop.
- Reset values:
  - state=IDLE, `pc`=0, `ack`=0, `commit`=0, `running`=0, `cycle_cnt`=0.
- IDLE:
  - `req`=1 → RUN; `ack` clears; `cycle_cnt` clears to 0.
  - `pc` is unchanged, so the next run resumes after the previous halt.
- RUN, with `halt`=1 (takes priority over every other input):
  - `commit`=0.
  - `pc` ← pc+1.
  - → DONE; `ack` ← 1.
- RUN, with `is_load`=1:
  - `commit`=0 in this cycle.
  - → LDWAIT; `pc` holds.
- RUN, otherwise:
  - `commit`=1.
  - `pc` ← `branch_target` if `branch_en`, else pc+1.
- LDWAIT:
  - `commit`=1, so the load data is written to the RF.
  - `pc` ← pc+1; → RUN.
  - `branch_en` is ignored in this state.
- DONE:
  - `ack`=1, `commit`=0.
  - `req`=0 → IDLE, with `ack` held at 1.
  - `req`=1 → stay in DONE. A `req` level still high from the same pulse never retriggers a run.
- PC arithmetic:
  - Modulo 2^PC_W; pc = 2^PC_W−1 increments to 0.
  - `branch_target` is used verbatim.
- `cycle_cnt`:
  - Increments in every RUN and LDWAIT cycle.
  - Saturates at 2^CNT_W−1.
  - Holds in IDLE and DONE.
- `commit` is combinational from state and inputs, and is never high outside RUN and LDWAIT.
- Reset while in any state: next edge state=IDLE, `pc`=0, `ack`=0. An in-flight load is abandoned with no commit in the reset cycle.

## Timing
- Start: `req`=1 sampled at edge e0 → RUN from e0; `ack`=0 from e0.
- Program of N single-cycle instructions plus halt:
  - Instructions execute in cycles e0 … e0+N−1.
  - Halt is in cycle e0+N.
  - `ack` rises at edge e0+N+1.
- Each load adds exactly one cycle. Each branch adds none.
- `ack` latency from the halt cycle is 1 edge.
- `ack` falls 1 edge after `req` is sampled high in IDLE.
- Minimum gap between runs: `req` must be seen low for at least 1 cycle after DONE.
- `pc`, `ack`, `running` and `cycle_cnt` are registered outputs. `commit` is combinational.

## Test plan
- Reset with `req`=1, then release reset. Program: addi, addi, halt at pc 0..2.
  - Required: RUN for 3 cycles.
  - Required: `commit` high in exactly 2 cycles.
  - Required: `ack`=1 at edge e0+3; `pc`=3; `cycle_cnt`=3.
- Second pulse with `pc`=3. Program: ld at 3, halt at 4.
  - Required: LDWAIT visited once.
  - Required: `commit` high only in the LDWAIT cycle.
  - Required: `ack` after 3 run cycles; `pc`=5.
- Taken branch: `branch_en`=1 with `branch_target`=0x000 at pc 7.
  - Required: next `pc`=0.
  - Required: `commit`=1 in that cycle.
- `req` held high for 20 cycles across a 2-instruction run.
  - Required: exactly one run; state remains DONE with `ack`=1 until `req`=0.
- `pc`=2^PC_W−1 holding a non-branch instruction.
  - Required: wraps to 0.
- Reset asserted in LDWAIT.
  - Required: next cycle IDLE, `pc`=0, `ack`=0, no commit.

Source files
------------

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - ROE core run sequencer: program counter, req/ack handshake, commit strobe
module run_ctrl #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  output logic             ack,
  input  logic             halt,
  input  logic             is_load,
  input  logic             branch_en,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic             commit,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_LDWAIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_next;
  logic [PC_W-1:0]   w_pc_inc;
  logic              r_ack;
  logic              w_ack_next;
  logic              r_running;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_commit;

  // Wraps naturally at 2^PC_W because the sum is truncated to PC_W bits.
  assign w_pc_inc = r_pc + PC_ONE;

  // Next-state, next-PC and commit decode; halt outranks load, load outranks branch.
  always_comb begin
    w_next     = r_state;
    w_pc_next  = r_pc;
    w_ack_next = r_ack;
    w_commit   = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_next     = S_RUN;
          w_ack_next = 1'b0;
          w_cnt_clr  = 1'b1;
        end
      end
      S_RUN: begin
        w_cnt_inc = 1'b1;
        if (halt) begin
          w_pc_next  = w_pc_inc;
          w_next     = S_DONE;
          w_ack_next = 1'b1;
        end else if (is_load) begin
          w_next = S_LDWAIT;
        end else begin
          w_commit  = 1'b1;
          w_pc_next = branch_en ? branch_target : w_pc_inc;
        end
      end
      S_LDWAIT: begin
        w_cnt_inc = 1'b1;
        w_commit  = 1'b1;
        w_pc_next = w_pc_inc;
        w_next    = S_RUN;
      end
      S_DONE: begin
        w_ack_next = 1'b1;
        if (!req) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // PC, ack, running flag and saturating run-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_ack     <= 1'b0;
      r_running <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_pc      <= w_pc_next;
      r_ack     <= w_ack_next;
      r_running <= (w_next == S_RUN) || (w_next == S_LDWAIT);
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // A reset cycle never commits, so an abandoned load leaves the RF untouched.
  assign commit    = w_commit & ~reset;
  assign pc        = r_pc;
  assign ack       = r_ack;
  assign running   = r_running;
  assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - randomized self-checking bench for run_ctrl against a program-walk model
module tb_run_ctrl;

  localparam int PC_W    = 10;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [1:0] OP_ALU  = 2'd0;
  localparam logic [1:0] OP_LD   = 2'd1;
  localparam logic [1:0] OP_BR   = 2'd2;
  localparam logic [1:0] OP_HALT = 2'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic             ack;
  logic             halt;
  logic             is_load;
  logic             branch_en;
  logic [PC_W-1:0]  branch_target;
  logic [PC_W-1:0]  pc;
  logic             commit;
  logic             running;
  logic [CNT_W-1:0] cycle_cnt;

  // Instruction memory seen by the decoder; noise bits raise lower-priority decode lines.
  logic [1:0]      mem_op  [DEPTH];
  logic [PC_W-1:0] mem_tgt [DEPTH];
  bit              nz_ld   [DEPTH];
  bit              nz_br   [DEPTH];

  // Expected per-cycle trace of one run: fetch address and commit.
  int exp_pc [$];
  int exp_cm [$];

  int n_vec = 0;
  int n_err = 0;
  int cur_pc;

  run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .ack           (ack),
    .halt          (halt),
    .is_load       (is_load),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .pc            (pc),
    .commit        (commit),
    .running       (running),
    .cycle_cnt     (cycle_cnt)
  );

  always #5 clk = ~clk;

  assign halt          = (mem_op[pc] == OP_HALT);
  assign is_load       = (mem_op[pc] == OP_LD) || ((mem_op[pc] == OP_HALT) && nz_ld[pc]);
  assign branch_en     = (mem_op[pc] == OP_BR) ||
                         (((mem_op[pc] == OP_LD) || (mem_op[pc] == OP_HALT)) && nz_br[pc]);
  assign branch_target = mem_tgt[pc];

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic put(input int a, input logic [1:0] op, input int t);
    mem_op[a]  = op;
    mem_tgt[a] = PC_W'(t);
    nz_ld[a]   = 1'b0;
    nz_br[a]   = 1'b0;
  endtask

  task automatic tp(input int p, input int c);
    exp_pc.push_back(p);
    exp_cm.push_back(c);
  endtask

  // Lay out a loop-free random program starting at 'start' and record its trace.
  task automatic gen_run(input int start, input int n, input bit plain, output int fin);
    bit used [DEPTH];
    int a;
    int ty;
    int nxt;
    int t;
    for (int i = 0; i < DEPTH; i++) used[i] = 1'b0;
    exp_pc.delete();
    exp_cm.delete();
    a = start;
    for (int k = 0; k < n; k++) begin
      used[a] = 1'b1;
      ty  = plain ? 0 : int'($urandom_range(0, 2));
      nxt = (a + 1) % DEPTH;
      if (ty != 2 && used[nxt]) ty = 2;
      mem_tgt[a] = PC_W'($urandom_range(0, DEPTH - 1));
      nz_ld[a]   = 1'($urandom_range(0, 1));
      nz_br[a]   = 1'($urandom_range(0, 1));
      case (ty)
        0: begin
          mem_op[a] = OP_ALU;
          tp(a, 1);
          a = nxt;
        end
        1: begin
          mem_op[a] = OP_LD;
          tp(a, 0);
          tp(a, 1);
          a = nxt;
        end
        default: begin
          do t = int'($urandom_range(0, DEPTH - 1)); while (used[t]);
          mem_op[a]  = OP_BR;
          mem_tgt[a] = PC_W'(t);
          tp(a, 1);
          a = t;
        end
      endcase
    end
    mem_op[a]  = OP_HALT;
    mem_tgt[a] = PC_W'($urandom_range(0, DEPTH - 1));
    nz_ld[a]   = 1'($urandom_range(0, 1));
    nz_br[a]   = 1'($urandom_range(0, 1));
    tp(a, 0);
    fin = (a + 1) % DEPTH;
  endtask

  // Launch a run from IDLE, check every cycle against the trace, keep req high
  // 'hold' extra cycles in DONE, then drop req and check the return to IDLE.
  task automatic do_run(input int fin, input int hold);
    int len;
    len   = exp_pc.size();
    req   = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk("run_running", int'(running), 1);
      chk("run_pc", int'(pc), exp_pc[i]);
      chk("run_commit", int'(commit), exp_cm[i]);
      chk("run_ack", int'(ack), 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_ack", int'(ack), 1);
    chk("done_running", int'(running), 0);
    chk("done_pc", int'(pc), fin);
    chk("done_cnt", int'(cycle_cnt), (len > CNT_MAX) ? CNT_MAX : len);
    chk("done_commit", int'(commit), 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_ack", int'(ack), 1);
      chk("hold_running", int'(running), 0);
      chk("hold_pc", int'(pc), fin);
    end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_ack", int'(ack), 1);
    chk("idle_running", int'(running), 0);
    chk("idle_pc", int'(pc), fin);
    chk("idle_cnt", int'(cycle_cnt), (len > CNT_MAX) ? CNT_MAX : len);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) put(i, OP_ALU, 0);
    reset = 1'b1;
    req   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", int'(pc), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_commit", int'(commit), 0);
    chk("rst_cnt", int'(cycle_cnt), 0);

    // addi, addi, halt from pc 0 with req already high out of reset.
    put(0, OP_ALU, 0); put(1, OP_ALU, 0); put(2, OP_HALT, 0);
    exp_pc.delete(); exp_cm.delete();
    tp(0, 1); tp(1, 1); tp(2, 0);
    do_run(3, 0);

    // ld at 3, halt at 4: commit only in the load's second cycle.
    put(3, OP_LD, 0); put(4, OP_HALT, 0);
    exp_pc.delete(); exp_cm.delete();
    tp(3, 0); tp(3, 1); tp(4, 0);
    do_run(5, 0);

    // Taken branch at pc 7 to address 0.
    put(5, OP_ALU, 0); put(6, OP_ALU, 0); put(7, OP_BR, 0); put(0, OP_HALT, 0);
    exp_pc.delete(); exp_cm.delete();
    tp(5, 1); tp(6, 1); tp(7, 1); tp(0, 0);
    do_run(1, 0);

    // Two-instruction run with req held for 20 cycles total.
    put(1, OP_ALU, 0); put(2, OP_HALT, 0);
    exp_pc.delete(); exp_cm.delete();
    tp(1, 1); tp(2, 0);
    do_run(3, 18);

    // Non-branch instruction at the top address wraps to 0.
    put(3, OP_BR, DEPTH - 1); put(DEPTH - 1, OP_ALU, 0); put(0, OP_HALT, 0);
    exp_pc.delete(); exp_cm.delete();
    tp(3, 1); tp(DEPTH - 1, 1); tp(0, 0);
    do_run(1, 0);

    // Long straight-line run saturates the cycle counter.
    gen_run(1, 20, 1'b1, cur_pc);
    do_run(cur_pc, 1);

    // Reset while in LDWAIT abandons the load.
    put(cur_pc, OP_LD, 0); put((cur_pc + 1) % DEPTH, OP_HALT, 0);
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ldrst_first_commit", int'(commit), 0);
    chk("ldrst_first_pc", int'(pc), cur_pc);
    @(posedge clk);
    @(negedge clk);
    chk("ldrst_wait_commit", int'(commit), 1);
    chk("ldrst_wait_pc", int'(pc), cur_pc);
    reset = 1'b1;
    #1;
    chk("ldrst_reset_commit", int'(commit), 0);
    @(posedge clk);
    @(negedge clk);
    chk("ldrst_pc", int'(pc), 0);
    chk("ldrst_ack", int'(ack), 0);
    chk("ldrst_running", int'(running), 0);
    chk("ldrst_commit", int'(commit), 0);
    req   = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ldrst_idle_running", int'(running), 0);
    chk("ldrst_idle_pc", int'(pc), 0);
    cur_pc = 0;

    // Randomized programs with loads, branches and decode-priority noise.
    for (int r = 0; r < 40; r++) begin
      gen_run(cur_pc, int'($urandom_range(1, 20)), 1'b0, cur_pc);
      do_run(cur_pc, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
